uart_controller: RTL

UART_CONTROLLER -- requirements
Module: uart_controller

---
 rtl/uart_controller.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_controller.sv
// UART transmitter/receiver with 16x oversampled receive and a one-byte receive holding register.
// Define UART_PARITY_EN to add an even parity bit after D7 (11-bit frame); otherwise the frame is 10 bits.
module uart_controller #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] UART_TXD,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic [7:0] UART_RXD,
  output logic       RX_EFF,
  input  logic       RX_READ,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [2:0] tx_state_dbg,
  output logic [2:0] rx_state_dbg
);

  localparam int TICK_DIV = CLK_HZ / (BAUD * 16);
  localparam int BIT_CLKS = 16 * TICK_DIV;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(BIT_CLKS);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] TX_PARITY = 3'd3;
`endif
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PARITY    = 3'd3;
`endif
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // Handshakes: TX_EN is a level whose 0->1 edge in TX_IDLE starts a frame (TX_STATUS=1 means
  // a start will be accepted); RX_EFF=1 marks UART_RXD unread and any cycle with RX_READ=1 consumes it.

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  logic [2:0]    tx_state;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line;
  logic          tx_idle;
  logic          tx_en_d;
  logic          tx_bit_end;
`ifdef UART_PARITY_EN
  logic          tx_par;
`endif

  assign tx_bit_end = (tx_cnt == BW'(BIT_CLKS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
      tx_idle  <= 1'b1;
      tx_en_d  <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_en_d <= TX_EN;
      if (tx_state != TX_IDLE) tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (TX_EN && !tx_en_d) begin
            tx_state <= TX_START;
            tx_shift <= UART_TXD;
            tx_line  <= 1'b0;
            tx_idle  <= 1'b0;
            tx_cnt   <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= ^UART_TXD;
`endif
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_state <= TX_PARITY;
              tx_line  <= tx_par;
`else
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state <= TX_STOP;
            tx_line  <= 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_state <= TX_IDLE;
            tx_idle  <= 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          tx_line  <= 1'b1;
          tx_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx      = tx_line;
  assign TX_STATUS    = tx_idle;
  assign tx_state_dbg = tx_state;

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s;
  logic [2:0] rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic [7:0] rxd_r;
  logic       rx_eff_r;
  logic       rx_par_good;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], uart_rx};
  end

`ifdef UART_PARITY_EN
  logic rx_par_ok;
  assign rx_par_good = rx_par_ok;
`else
  assign rx_par_good = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rxd_r    <= '0;
      rx_eff_r <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_ok <= 1'b1;
`endif
    end else begin
      // A byte landing this cycle overrides the read-clear below (latest byte wins).
      if (RX_READ) rx_eff_r <= 1'b0;
      if (tick) rx_tcnt <= rx_tcnt + 1'b1;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            rx_tcnt  <= '0;
          end
        end
        RX_START: begin
          if (tick && rx_tcnt == 4'd7) begin
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (tick && rx_tcnt == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick && rx_tcnt == 4'd15) begin
            rx_par_ok <= (rx_s == ^rx_shift);
            rx_state  <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (tick && rx_tcnt == 4'd15) begin
            if (rx_s) begin
              rx_state <= RX_IDLE;
              if (rx_par_good) begin
                rxd_r    <= rx_shift;
                rx_eff_r <= 1'b1;
              end
            end else begin
              rx_state <= RX_WAIT_HIGH;
            end
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign UART_RXD     = rxd_r;
  assign RX_EFF       = rx_eff_r;
  assign rx_state_dbg = rx_state;

endmodule
